// File: rtl/mips_mc_core.sv
// ---------------------------------------------------------------------------
// mips_mc_core
//   Multicycle MIPS-subset core. Each 32-bit instruction is fetched as
//   BEATS = 32/DATA_W big-endian beats over a DATA_W-wide memory port with a
//   ready handshake, so any number of wait states is tolerated.
//   Supported: LD, ST, R-type (add/sub/and/or/slt), ADDI, BEQ, J, HALT.
//   Every other opcode executes as a NOP. r0 is hardwired to zero.
//
// Parameters
//   DATA_W  datapath / register / memory-beat width (8, 16 or 32)
//   ADDR_W  memory / PC address width in beats (<= DATA_W)
//   REG_AW  register index width, 2**REG_AW registers (<= 5)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   mem_rdata  in   read data, valid in the cycle mem_ready=1
//   mem_ready  in   completes the pending read/write request
//   mem_read   out  read request, held until mem_ready
//   mem_write  out  write request, held until mem_ready
//   mem_addr   out  beat address (PC or ALUOut)
//   mem_wdata  out  store data (register B) during a store, else zero
//   halted     out  core stopped on HALT, sticky until reset
// ---------------------------------------------------------------------------
module mips_mc_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              halted
);

    localparam int BEATS   = 32 / DATA_W;
    localparam int BEAT_SH = $clog2(BEATS);
    localparam int NREG    = 2 ** REG_AW;
    localparam int BCW     = 2;             // beat counter width, BEATS <= 4

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LD   = 6'b100000;
    localparam logic [5:0] OP_ST   = 6'b101000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_LDRD,
        S_LDWR,
        S_STWR,
        S_RTYPEEX,
        S_RTYPEWR,
        S_ADDIEX,
        S_ADDIWR,
        S_BEQEX,
        S_JEX,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   alu_out_q, alu_out_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [BCW-1:0]      beat_q, beat_d;

    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    // Instruction fields
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [REG_AW-1:0]   rs, rt, rd;
    logic [DATA_W-1:0]   imm_sext;   // sext(imm16) truncated to DATA_W
    logic [DATA_W-1:0]   br_off;     // imm scaled from words to beats
    logic [DATA_W-1:0]   pc_ext;     // PC zero-extended into the ALU
    logic [DATA_W-1:0]   r_result;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs       = ir_q[21 +: REG_AW];
    assign rt       = ir_q[16 +: REG_AW];
    assign rd       = ir_q[11 +: REG_AW];
    assign imm_sext = DATA_W'({{16{ir_q[15]}}, ir_q[15:0]});
    assign br_off   = imm_sext << BEAT_SH;
    assign pc_ext   = DATA_W'(pc_q);

    // -----------------------------------------------------------------------
    // Moore outputs: decoded from state only, so they stay stable while the
    // memory holds off with mem_ready=0.
    // -----------------------------------------------------------------------
    assign mem_read  = (state_q == S_FETCH) || (state_q == S_LDRD);
    assign mem_write = (state_q == S_STWR);
    assign mem_addr  = ((state_q == S_LDRD) || (state_q == S_STWR))
                       ? ADDR_W'(alu_out_q) : pc_q;
    assign mem_wdata = (state_q == S_STWR) ? b_q : '0;
    assign halted    = (state_q == S_HALT);

    // -----------------------------------------------------------------------
    // R-type ALU; unknown funct codes yield zero. slt is a direct signed
    // compare so it cannot be fooled by subtraction overflow.
    // -----------------------------------------------------------------------
    always_comb begin
        r_result = '0;
        case (funct)
            FN_ADD:  r_result = a_q + b_q;
            FN_SUB:  r_result = a_q - b_q;
            FN_AND:  r_result = a_q & b_q;
            FN_OR:   r_result = a_q | b_q;
            FN_SLT:  r_result = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
            default: r_result = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state / datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        beat_d    = beat_q;
        // A/B track the currently addressed registers every cycle; execute
        // states always follow DECODE, so they see the complete IR.
        a_d       = regs_q[rs];
        b_d       = regs_q[rt];
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out_q;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    // Beat 0 lands in the most significant slice (big-endian).
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_q == BCW'(b)) begin
                            ir_d[31 - b*DATA_W -: DATA_W] = mem_rdata;
                        end
                    end
                    pc_d = pc_q + ADDR_W'(1);
                    if (beat_q == BCW'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = S_DECODE;
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end
            end

            S_DECODE: begin
                // Speculative branch target; PC already points past the word.
                alu_out_d = pc_ext + br_off;
                case (opcode)
                    OP_LD, OP_ST: state_d = S_MEMADR;
                    OP_R:         state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_HALT:      state_d = S_HALT;
                    default:      state_d = S_FETCH;
                endcase
            end

            S_MEMADR: begin
                alu_out_d = a_q + imm_sext;
                state_d   = (opcode == OP_LD) ? S_LDRD : S_STWR;
            end

            S_LDRD: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_LDWR;
                end
            end

            S_LDWR: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = mdr_q;
                state_d  = S_FETCH;
            end

            S_STWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_RTYPEEX: begin
                alu_out_d = r_result;
                state_d   = S_RTYPEWR;
            end

            S_RTYPEWR: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                rf_wdata = alu_out_q;
                state_d  = S_FETCH;
            end

            S_ADDIEX: begin
                alu_out_d = a_q + imm_sext;
                state_d   = S_ADDIWR;
            end

            S_ADDIWR: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = alu_out_q;
                state_d  = S_FETCH;
            end

            S_BEQEX: begin
                if (a_q == b_q) begin
                    pc_d = ADDR_W'(alu_out_q);
                end
                state_d = S_FETCH;
            end

            S_JEX: begin
                // Word target scaled to beats, wrapped into the address space.
                pc_d    = ADDR_W'({6'b000000, ir_q[25:0]} << BEAT_SH);
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Register file next values; r0 is tied to zero so writes to it vanish.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign regs_d[gi] = '0;
            end else begin : g_reg
                assign regs_d[gi] = (rf_we && (rf_waddr == REG_AW'(gi)))
                                    ? rf_wdata : regs_q[gi];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            beat_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            beat_q    <= beat_d;
            regs_q    <= regs_d;
        end
    end

endmodule
